// File: rtl/sn74169_input_conditioner.sv
// Pad-input conditioner for an SN74169 up/down counter: synchronizes raw switches,
// debounces the step/load buttons and drives registered active-low counter strobes.

module sn74169_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic sync_i,
   output logic pulse_o
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] HELD         = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Press/release qualification; the pulse fires only on the IDLE-side acceptance.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_o = 1'b0;
      if (!ena) begin
         state_d = IDLE;
         cnt_d   = CNT_ZERO;
      end else begin
         case (state_q)
            IDLE: begin
               if (sync_i) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = IDLE;
                  cnt_d   = CNT_ZERO;
               end
            end
            PRESS_WAIT: begin
               if (!sync_i) begin
                  state_d = IDLE;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = HELD;
                  pulse_o = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            HELD: begin
               if (!sync_i) begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = HELD;
               end
            end
            RELEASE_WAIT: begin
               if (sync_i) begin
                  state_d = HELD;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = IDLE;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

module sn74169_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       raw_step,
   input  logic       raw_load,
   input  logic       raw_run,
   input  logic       raw_up,
   input  logic [3:0] raw_data,
   output logic       cnt_en_n,
   output logic       load_n,
   output logic       up_dn,
   output logic [3:0] data_out
);
   // Packed as {up, run, load, step, data}; the direction bit idles high.
   localparam int            SW       = 8;
   localparam logic [SW-1:0] SYNC_RST = 8'h80;

   logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
   logic [SW-1:0] raw_vec, sync_vec;
   logic          step_sync, load_sync, run_sync, up_sync;
   logic [3:0]    data_sync;
   logic          step_pulse, load_pulse;
   logic          cnt_en_n_q, cnt_en_n_d, load_n_q, load_n_d, up_dn_q, up_dn_d;
   logic [3:0]    data_q, data_d;

   assign raw_vec   = {raw_up, raw_run, raw_load, raw_step, raw_data};
   assign sync_vec  = sync_q[SYNC_STAGES-1];
   assign up_sync   = sync_vec[7];
   assign run_sync  = sync_vec[6];
   assign load_sync = sync_vec[5];
   assign step_sync = sync_vec[4];
   assign data_sync = sync_vec[3:0];

   // Synchronizer chains for every pad input; they keep sampling regardless of ena.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{SYNC_RST}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_vec};
      end
   end

   sn74169_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_deb (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sync_i(step_sync), .pulse_o(step_pulse)
   );

   sn74169_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_deb (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sync_i(load_sync), .pulse_o(load_pulse)
   );

   // Strobe shaping: load wins over count, and direction only moves while the counter is idle.
   always_comb begin
      if (ena) begin
         load_n_d   = ~load_pulse;
         cnt_en_n_d = ~((step_pulse | run_sync) & ~load_pulse);
         data_d     = load_pulse ? data_sync : data_q;
      end else begin
         load_n_d   = 1'b1;
         cnt_en_n_d = 1'b1;
         data_d     = data_q;
      end
      if (cnt_en_n_d && load_n_d) begin
         up_dn_d = up_sync;
      end else begin
         up_dn_d = up_dn_q;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_en_n_q <= 1'b1;
         load_n_q   <= 1'b1;
         up_dn_q    <= 1'b1;
         data_q     <= 4'h0;
      end else begin
         cnt_en_n_q <= cnt_en_n_d;
         load_n_q   <= load_n_d;
         up_dn_q    <= up_dn_d;
         data_q     <= data_d;
      end
   end

   assign cnt_en_n = cnt_en_n_q;
   assign load_n   = load_n_q;
   assign up_dn    = up_dn_q;
   assign data_out = data_q;
endmodule

// File: tb/tb_sn74169_input_conditioner.sv
// Directed bench for sn74169_input_conditioner: a run-length debounce model checked every
// cycle, plus literal timing/value expectations for each scenario.

module tb_sn74169_input_conditioner;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic       clk = 1'b0;
   logic       rst_n, ena, raw_step, raw_load, raw_run, raw_up;
   logic [3:0] raw_data;
   logic       cnt_en_n, load_n, up_dn;
   logic [3:0] data_out;

   int checks   = 0;
   int failures = 0;

   // Model state: input history per edge, debounce as accepted level + opposite-run length.
   logic [7:0] h_bits [0:4095];
   int         m_edge;
   logic       m_pr  [2];
   int         m_run [2];
   logic       m_cnt, m_ld, m_up;
   logic [3:0] m_data;

   sn74169_input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .raw_step(raw_step), .raw_load(raw_load),
      .raw_run(raw_run), .raw_up(raw_up), .raw_data(raw_data),
      .cnt_en_n(cnt_en_n), .load_n(load_n), .up_dn(up_dn), .data_out(data_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_edge = 0;
      for (int b = 0; b < 2; b++) begin
         m_pr[b]  = 1'b0;
         m_run[b] = 0;
      end
      m_cnt  = 1'b1;
      m_ld   = 1'b1;
      m_up   = 1'b1;
      m_data = 4'h0;
   endtask

   // A level is accepted once DEB+1 consecutive samples disagree with the current one.
   task automatic deb(input int b, input logic s, output logic pulse);
      pulse = 1'b0;
      if (!ena) begin
         m_pr[b]  = 1'b0;
         m_run[b] = 0;
      end else if (s == m_pr[b]) begin
         m_run[b] = 0;
      end else begin
         m_run[b]++;
         if (m_run[b] == DEB + 1) begin
            m_pr[b]  = s;
            m_run[b] = 0;
            pulse    = s;
         end
      end
   endtask

   task automatic model_edge();
      int         idx;
      logic [7:0] s;
      logic       sp, lp;
      m_edge++;
      h_bits[m_edge % 4096] = {raw_up, raw_run, raw_load, raw_step, raw_data};
      idx = m_edge - SYNC;
      s   = (idx < 1) ? 8'h80 : h_bits[idx % 4096];
      deb(0, s[4], sp);
      deb(1, s[5], lp);
      if (ena) begin
         m_ld  = ~lp;
         m_cnt = ~((sp | s[6]) & ~lp);
         if (lp) m_data = s[3:0];
      end else begin
         m_ld  = 1'b1;
         m_cnt = 1'b1;
      end
      if (m_cnt && m_ld) m_up = s[7];
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      @(negedge clk);
      chk("cycle_outputs", int'({cnt_en_n, load_n, up_dn, data_out}),
          int'({m_cnt, m_ld, m_up, m_data}));
   endtask

   task automatic watch(input int n, output int en_lows, output int ld_lows,
                        output int first_en, output int data_at_ld, output int en_at_ld);
      en_lows = 0; ld_lows = 0; first_en = 0; data_at_ld = -1; en_at_ld = -1;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (cnt_en_n == 1'b0) begin
            en_lows++;
            if (first_en == 0) first_en = i;
         end
         if (load_n == 1'b0) begin
            ld_lows++;
            data_at_ld = int'(data_out);
            en_at_ld   = int'(cnt_en_n);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int en_l, ld_l, f_en, d_ld, e_ld, en_acc, up_first;

   initial begin
      rst_n = 1'b0; ena = 1'b1; raw_step = 1'b0; raw_load = 1'b0; raw_run = 1'b0;
      raw_up = 1'b1; raw_data = 4'h0;
      model_reset();
      idle(2);
      chk("reset_cnt_en_n", int'(cnt_en_n), 1);
      chk("reset_load_n", int'(load_n), 1);
      chk("reset_up_dn", int'(up_dn), 1);
      chk("reset_data_out", int'(data_out), 0);
      rst_n = 1'b1;
      idle(3);

      // Clean press: strobe only at the 7th edge after the first high sample.
      raw_step = 1'b1;
      watch(20, en_l, ld_l, f_en, d_ld, e_ld);
      chk("clean_first_edge", f_en, 7);
      chk("clean_strobe_count", en_l, 1);
      chk("clean_no_load", ld_l, 0);
      raw_step = 1'b0;
      idle(10);

      // Press bounce with 2-cycle highs is rejected.
      en_acc = 0;
      for (int i = 0; i < 8; i++) begin
         raw_step = (i % 4) < 2;
         watch(1, en_l, ld_l, f_en, d_ld, e_ld);
         en_acc += en_l;
      end
      raw_step = 1'b0;
      watch(10, en_l, ld_l, f_en, d_ld, e_ld);
      chk("bounce_no_strobe", en_acc + en_l, 0);

      // Accepted press followed by release bounce with 3-cycle lows.
      raw_step = 1'b1;
      watch(10, en_l, ld_l, f_en, d_ld, e_ld);
      en_acc = en_l;
      for (int i = 0; i < 10; i++) begin
         raw_step = (i % 5) >= 3;
         watch(1, en_l, ld_l, f_en, d_ld, e_ld);
         en_acc += en_l;
      end
      raw_step = 1'b0;
      watch(10, en_l, ld_l, f_en, d_ld, e_ld);
      chk("release_bounce_single", en_acc + en_l, 1);

      // Load with data, then data changes without a press.
      raw_data = 4'hA; raw_load = 1'b1;
      watch(10, en_l, ld_l, f_en, d_ld, e_ld);
      chk("load_count", ld_l, 1);
      chk("load_data_same_cycle", d_ld, 10);
      raw_load = 1'b0; raw_data = 4'h3;
      idle(12);
      chk("load_data_holds", int'(data_out), 10);

      // Step and load on the same edge: load only.
      raw_data = 4'h5; raw_step = 1'b1; raw_load = 1'b1;
      watch(12, en_l, ld_l, f_en, d_ld, e_ld);
      chk("collide_load_count", ld_l, 1);
      chk("collide_no_count", en_l, 0);
      chk("collide_data", int'(data_out), 5);
      raw_step = 1'b0; raw_load = 1'b0;
      idle(10);

      // Run mode and direction freezing.
      raw_run = 1'b1;
      watch(3, en_l, ld_l, f_en, d_ld, e_ld);
      chk("run_first_edge", f_en, 3);
      raw_up = 1'b0;
      idle(6);
      chk("run_up_frozen", int'(up_dn), 1);
      raw_data = 4'hC; raw_load = 1'b1;
      watch(10, en_l, ld_l, f_en, d_ld, e_ld);
      chk("run_load_count", ld_l, 1);
      chk("run_load_en_high", e_ld, 1);
      chk("run_load_data", d_ld, 12);
      raw_load = 1'b0;
      idle(8);
      chk("run_up_still_frozen", int'(up_dn), 1);
      raw_run = 1'b0;
      up_first = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (up_dn == 1'b0 && up_first == 0) up_first = i;
      end
      chk("stop_up_follows", up_first, 3);

      // Enable dropped mid-debounce, re-enabled with the button still held.
      raw_step = 1'b1;
      watch(4, en_l, ld_l, f_en, d_ld, e_ld);
      en_acc = en_l;
      ena = 1'b0;
      watch(3, en_l, ld_l, f_en, d_ld, e_ld);
      chk("ena_low_no_strobe", en_acc + en_l, 0);
      ena = 1'b1;
      watch(10, en_l, ld_l, f_en, d_ld, e_ld);
      chk("ena_return_first", f_en, 5);
      chk("ena_return_count", en_l, 1);
      raw_step = 1'b0;
      idle(10);

      // Asynchronous reset in the middle of a strobe.
      raw_step = 1'b1;
      idle(6);
      tick();
      chk("strobe_before_reset", int'(cnt_en_n), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_cnt_en_n", int'(cnt_en_n), 1);
      chk("async_rst_load_n", int'(load_n), 1);
      chk("async_rst_up_dn", int'(up_dn), 1);
      chk("async_rst_data", int'(data_out), 0);
      model_reset();
      idle(2);
      rst_n = 1'b1;
      watch(12, en_l, ld_l, f_en, d_ld, e_ld);
      chk("post_reset_strobe", en_l, 1);
      raw_step = 1'b0;
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
